// File: rtl/scaler_pkg.sv
// Shared scaler definitions: configuration FSM encoding, default scale constant
// and small arithmetic helpers used by the vertical scaler configuration logic.
package scaler_pkg;

    localparam int unsigned LINE_STEP_DEFAULT = 32'd4096;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CHECK   = 2'd1,
        ST_PENDING = 2'd2
    } cfg_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        if (value == 16'hFFFF) begin
            sat_inc16 = 16'hFFFF;
        end else begin
            sat_inc16 = value + 16'd1;
        end
    endfunction

    function automatic logic in_range16(
        input logic [15:0] value,
        input logic [15:0] lo,
        input logic [15:0] hi
    );
        in_range16 = (value >= lo) && (value <= hi);
    endfunction

endpackage

// File: rtl/scaler_v_cfg.sv
// Vertical scaler configuration port: accepts a step/line-size offer, checks it,
// and applies it only at an input frame start. Also tracks input frame statistics.
module scaler_v_cfg
    import scaler_pkg::*;
#(
    parameter int unsigned LINE_IN_SIZE_MAX = 32'd1024,
    parameter int unsigned LINE_STEP        = LINE_STEP_DEFAULT,
    parameter int unsigned STEP_MIN         = 32'd1024,
    parameter int unsigned STEP_MAX         = 32'd16384
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cfg_step,
    input  logic [15:0] cfg_line_size,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic        cfg_cancel,
    input  logic        de_i,
    input  logic        hs_i,
    input  logic        vs_i,
    output logic [15:0] v_scale_step,
    output logic [15:0] v_scale_line_size,
    output logic        cfg_applied,
    output logic        cfg_err,
    output logic [15:0] frame_cnt,
    output logic [15:0] frame_lines
);

    localparam logic [15:0] RST_STEP  = 16'(LINE_STEP);
    localparam logic [15:0] RST_SIZE  = 16'(LINE_IN_SIZE_MAX - 32'd1);
    localparam logic [15:0] STEP_LO   = 16'(STEP_MIN);
    localparam logic [15:0] STEP_HI   = 16'(STEP_MAX);

    cfg_state_e  state_r;
    cfg_state_e  state_nxt_s;
    logic        cfg_ready_r;
    logic [15:0] shadow_step_r;
    logic [15:0] shadow_size_r;
    logic [15:0] act_step_r;
    logic [15:0] act_size_r;
    logic        applied_r;
    logic        err_r;
    logic [15:0] line_cnt_r;
    logic [15:0] frame_cnt_r;
    logic [15:0] frame_lines_r;
    logic        seen_frame_r;

    logic        transfer_s;
    logic        frame_start_s;
    logic        line_start_s;
    logic        legal_s;
    logic        apply_s;
    logic        reject_s;
    logic        discard_s;

    assign transfer_s    = cfg_valid && cfg_ready_r;
    assign frame_start_s = de_i && vs_i;
    assign line_start_s  = de_i && hs_i && !vs_i;
    assign legal_s       = in_range16(shadow_step_r, STEP_LO, STEP_HI) &&
                           (shadow_size_r <= RST_SIZE);

    // Next-state and one-cycle action decode for the configuration FSM
    always_comb begin
        state_nxt_s = state_r;
        apply_s     = 1'b0;
        reject_s    = 1'b0;
        discard_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (transfer_s) begin
                    state_nxt_s = ST_CHECK;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CHECK: begin
                // A frame start seen here is deliberately ignored; the offer is not yet vetted.
                if (legal_s) begin
                    state_nxt_s = ST_PENDING;
                end else begin
                    state_nxt_s = ST_IDLE;
                    reject_s    = 1'b1;
                end
            end
            ST_PENDING: begin
                if (cfg_cancel) begin
                    state_nxt_s = ST_IDLE;
                    discard_s   = 1'b1;
                end else if (frame_start_s) begin
                    state_nxt_s = ST_IDLE;
                    apply_s     = 1'b1;
                end else begin
                    state_nxt_s = ST_PENDING;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state and registered ready flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cfg_ready_r <= 1'b1;
        end else begin
            state_r     <= state_nxt_s;
            cfg_ready_r <= (state_nxt_s == ST_IDLE);
        end
    end

    // Shadow capture on transfer; cleared when the offer is rejected, cancelled or consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_step_r <= 16'd0;
            shadow_size_r <= 16'd0;
        end else if (transfer_s) begin
            shadow_step_r <= cfg_step;
            shadow_size_r <= cfg_line_size;
        end else if (reject_s || discard_s || apply_s) begin
            shadow_step_r <= 16'd0;
            shadow_size_r <= 16'd0;
        end else begin
            shadow_step_r <= shadow_step_r;
            shadow_size_r <= shadow_size_r;
        end
    end

    // Active configuration and status pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_step_r <= RST_STEP;
            act_size_r <= RST_SIZE;
            applied_r  <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            if (apply_s) begin
                act_step_r <= shadow_step_r;
                act_size_r <= shadow_size_r;
            end else begin
                act_step_r <= act_step_r;
                act_size_r <= act_size_r;
            end
            applied_r <= apply_s;
            err_r     <= reject_s;
        end
    end

    // Input frame statistics: line counter, completed-frame line count and frame counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_cnt_r    <= 16'd0;
            frame_cnt_r   <= 16'd0;
            frame_lines_r <= 16'd0;
            seen_frame_r  <= 1'b0;
        end else if (frame_start_s) begin
            // The first frame start has no completed frame behind it.
            frame_lines_r <= seen_frame_r ? line_cnt_r : 16'd0;
            frame_cnt_r   <= frame_cnt_r + 16'd1;
            line_cnt_r    <= 16'd1;
            seen_frame_r  <= 1'b1;
        end else if (line_start_s) begin
            line_cnt_r    <= sat_inc16(line_cnt_r);
        end else begin
            line_cnt_r    <= line_cnt_r;
        end
    end

    assign cfg_ready         = cfg_ready_r;
    assign v_scale_step      = act_step_r;
    assign v_scale_line_size = act_size_r;
    assign cfg_applied       = applied_r;
    assign cfg_err           = err_r;
    assign frame_cnt         = frame_cnt_r;
    assign frame_lines       = frame_lines_r;

endmodule
